pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It works alongside the EX-stage forwarding logic and handles the hazards that forwarding cannot resolve:
- load-use stalls
- taken-branch flushes
- multi-cycle MUL/DIV occupancy in EX
- variable-latency data-memory waits in MEM

It drives write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps a stall-cycle counter and a memory watchdog.

Parameters:
MEM_TIMEOUT, 255, consecutive mem-wait cycles before mem_timeout_err sets (1..2^16-1)
CNT_W, 32, width of stall_count

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_ex_rd  in  5  rd of instruction in EX
id_ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved branch/jump taken
ex_md_valid  in  1  EX holds a MUL/DIV op
md_done  in  1  MUL/DIV result ready (1-cycle pulse)
mem_req  in  1  MEM stage issuing data-memory access
mem_ack  in  1  data memory completes access this cycle
pc_write  out  1  PC loads next value
if_id_write  out  1  IF/ID loads
if_id_flush  out  1  IF/ID loads bubble (overrides write)
id_ex_write  out  1  ID/EX loads
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_write  out  1  EX/MEM loads
ex_mem_flush  out  1  EX/MEM loads bubble
mem_wb_flush  out  1  MEM/WB loads bubble
md_start  out  1  1-cycle start pulse to MUL/DIV unit
mem_timeout_err  out  1  sticky watchdog flag
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Registered state:
  - FSM {RUN, MD_BUSY}
  - done_q: md_done latched while mem-stalled
  - tmo_cnt: mem-wait cycles
  - mem_timeout_err
  - stall_count
- Control outputs are combinational (Mealy) from state and inputs. They take effect in the same cycle.
- Reset (rst_n=0, async): state=RUN, done_q=0, tmo_cnt=0, mem_timeout_err=0, stall_count=0.
  - With idle inputs, the outputs are: all *_write=1, all flushes=0, md_start=0.
- Default in each cycle: all *_write=1, all flushes=0, md_start=0.
- load_use = id_ex_mem_read & (id_ex_rd!=0) & ((id_uses_rs1 & id_rs1==id_ex_rd) | (id_uses_rs2 & id_rs2==id_ex_rd)).
- md_fin = md_done | done_q.
- Rules are evaluated in priority order; the first match wins:
  1. Mem stall (mem_req & !mem_ack), in any state:
     - pc/if_id/id_ex/ex_mem write=0, mem_wb_flush=1.
     - Branch and load-use are ignored; they re-evaluate next cycle because the pipeline holds.
     - md_start=0.
     - If state=MD_BUSY and md_done, set done_q.
     - tmo_cnt increments, saturating. When tmo_cnt reaches MEM_TIMEOUT, mem_timeout_err=1 until reset.
  2. MD_BUSY & !md_fin:
     - pc/if_id/id_ex write=0, ex_mem_flush=1. Stay in MD_BUSY.
  3. MD_BUSY & md_fin:
     - Go to RUN and clear done_q.
     - Outputs follow rules 5-7 this cycle, so the MD result advances into EX/MEM.
     - md_start=0 even though ex_md_valid is still high.
  4. RUN & ex_md_valid:
     - md_start=1, go to MD_BUSY, outputs as rule 2.
  5. ex_branch_taken: if_id_flush=1, id_ex_flush=1; writes stay 1.
  6. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Lasts exactly one cycle.
  7. Otherwise default.
- tmo_cnt clears on any cycle without a mem stall.
- md_done while in RUN, outside the rule-3 path, is ignored.
- stall_count increments on cycles matching rule 1, 2, 4 or 6. Branch flushes do not count. It saturates at all-ones.
- Reset mid-operation aborts MD_BUSY immediately. No md_start is reissued until ex_md_valid is seen in RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM encoding (RUN=1'b0, MD_BUSY=1'b1)
  - REG_ZERO=5'd0
  - forwarding-select constants (FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10) so this block and the forwarding logic agree
- One sub-module, load_use_detect: purely combinational load_use equation, reused by future dual-issue work.

Test Plan:
- Load x5 in EX (id_ex_rd=5, mem_read=1), ID add reads rs2=x5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, stall_count 0->1. Same case with id_ex_rd=0 -> no stall.
- ex_branch_taken=1 in RUN -> if_id_flush=1, id_ex_flush=1, pc_write=1, stall_count unchanged.
- ex_md_valid=1, md_done after 4 cycles -> md_start pulses once, then 4 cycles of frozen PC/IF/ID/ID-EX with ex_mem_flush=1, then release. stall_count=5.
- MD_BUSY, mem_req=1 & mem_ack=0 for 3 cycles with md_done pulsed in cycle 2 -> done_q captures it, and MD releases on the first cycle after mem_ack with no further md_done.
- MEM_TIMEOUT=8, mem_req=1 & mem_ack=0 for 10 cycles -> mem_timeout_err rises after the 8th stall cycle and stays 1 after ack until rst_n low.
- rst_n asserted mid-MD_BUSY -> outputs immediately return to defaults, counters=0. ex_md_valid after reset -> new md_start.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and the EX-stage forwarding logic.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned TMO_W = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_e;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline stages and the stall/flush controls returned to them.
interface pipeline_hazard_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [pipe_ctrl_pkg::REG_W-1:0] id_rs1;
    logic [pipe_ctrl_pkg::REG_W-1:0] id_rs2;
    logic                            id_uses_rs1;
    logic                            id_uses_rs2;
    logic [pipe_ctrl_pkg::REG_W-1:0] id_ex_rd;
    logic                            id_ex_mem_read;
    logic                            ex_branch_taken;
    logic                            ex_md_valid;
    logic                            md_done;
    logic                            mem_req;
    logic                            mem_ack;

    logic                            pc_write;
    logic                            if_id_write;
    logic                            if_id_flush;
    logic                            id_ex_write;
    logic                            id_ex_flush;
    logic                            ex_mem_write;
    logic                            ex_mem_flush;
    logic                            mem_wb_flush;
    logic                            md_start;
    logic                            mem_timeout_err;
    logic [CNT_W-1:0]                stall_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_mem_read,
               ex_branch_taken, ex_md_valid, md_done, mem_req, mem_ack,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, mem_wb_flush, md_start,
               mem_timeout_err, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_mem_read,
               ex_branch_taken, ex_md_valid, md_done, mem_req, mem_ack,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, mem_wb_flush, md_start,
               mem_timeout_err, stall_count
    );
endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_mem_read,
    output logic             load_use
);
    // x0 is never a real producer, so a load into it cannot create a hazard
    assign load_use = id_ex_mem_read && (id_ex_rd != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, MUL/DIV occupancy and
// data-memory waits, with a saturating stall counter and a sticky memory watchdog.
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_controller_if.slave  bus
);
    ctrl_state_e      state_q, state_d;
    logic             done_q, done_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic mem_stall;
    logic md_fin;
    logic free_flow;
    logic stall_cyc;
    logic [TMO_W-1:0] tmo_inc;

    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, ex_mem_flush, mem_wb_flush, md_start;

    load_use_detect u_load_use_detect (
        .id_rs1         (bus.id_rs1),
        .id_rs2         (bus.id_rs2),
        .id_uses_rs1    (bus.id_uses_rs1),
        .id_uses_rs2    (bus.id_uses_rs2),
        .id_ex_rd       (bus.id_ex_rd),
        .id_ex_mem_read (bus.id_ex_mem_read),
        .load_use       (load_use)
    );

    assign mem_stall = bus.mem_req && !bus.mem_ack;
    assign md_fin    = bus.md_done || done_q;
    assign tmo_inc   = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            done_q  <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: mem stall > MD occupancy > MD launch > branch flush > load-use
    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        tmo_d        = '0;
        err_d        = err_q;
        stall_cyc    = 1'b0;
        free_flow    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        md_start     = 1'b0;

        if (mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            stall_cyc    = 1'b1;
            tmo_d        = tmo_inc;
            if (tmo_inc >= TMO_W'(MEM_TIMEOUT)) begin
                err_d = 1'b1;
            end
            // A completion that arrives while frozen must not be lost
            if ((state_q == MD_BUSY) && bus.md_done) begin
                done_d = 1'b1;
            end
        end else if (state_q == MD_BUSY) begin
            if (!md_fin) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
                stall_cyc    = 1'b1;
            end else begin
                state_d   = RUN;
                done_d    = 1'b0;
                free_flow = 1'b1;
            end
        end else if (bus.ex_md_valid) begin
            md_start     = 1'b1;
            state_d      = MD_BUSY;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            stall_cyc    = 1'b1;
        end else begin
            free_flow = 1'b1;
        end

        if (free_flow) begin
            if (bus.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall_cyc   = 1'b1;
            end
        end

        cnt_d = (stall_cyc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign bus.pc_write        = pc_write;
    assign bus.if_id_write     = if_id_write;
    assign bus.if_id_flush     = if_id_flush;
    assign bus.id_ex_write     = id_ex_write;
    assign bus.id_ex_flush     = id_ex_flush;
    assign bus.ex_mem_write    = ex_mem_write;
    assign bus.ex_mem_flush    = ex_mem_flush;
    assign bus.mem_wb_flush    = mem_wb_flush;
    assign bus.md_start        = md_start;
    assign bus.mem_timeout_err = err_q;
    assign bus.stall_count     = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: vector table, corner sequences, random vs model.
module tb_pipeline_hazard_controller;
    import pipe_ctrl_pkg::*;

    localparam int unsigned TMO = 8;
    localparam int unsigned CW  = 32;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       mdv;
        logic       mdd;
        logic       mreq;
        logic       mack;
    } in_t;

    // {pc_w, if_id_w, if_id_fl, id_ex_w, id_ex_fl, ex_mem_w, ex_mem_fl, mem_wb_fl, md_start}
    typedef logic [8:0] ctrl_t;
    localparam ctrl_t C_DEF = 9'b110101000;
    localparam ctrl_t C_BR  = 9'b111111000;
    localparam ctrl_t C_LU  = 9'b000111000;
    localparam ctrl_t C_MEM = 9'b000000010;
    localparam ctrl_t C_MD  = 9'b000001100;
    localparam ctrl_t C_MDS = 9'b000001101;

    typedef struct {
        in_t   in;
        ctrl_t ctrl;
        int    inc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    bit          m_busy;
    bit          m_held;
    int          m_wait;
    bit          m_err;
    longint      m_stalls;

    function automatic in_t mk(int rs1, int rs2, bit u1, bit u2, int rd, bit ld,
                               bit br, bit mdv, bit mdd, bit mreq, bit mack);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
        v.ld = ld; v.br = br; v.mdv = mdv; v.mdd = mdd; v.mreq = mreq; v.mack = mack;
        return v;
    endfunction

    function automatic ctrl_t dut_ctrl();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                bus.id_ex_flush, bus.ex_mem_write, bus.ex_mem_flush, bus.mem_wb_flush,
                bus.md_start};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive(in_t v);
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_uses_rs1     = v.u1;
        bus.id_uses_rs2     = v.u2;
        bus.id_ex_rd        = v.rd;
        bus.id_ex_mem_read  = v.ld;
        bus.ex_branch_taken = v.br;
        bus.ex_md_valid     = v.mdv;
        bus.md_done         = v.mdd;
        bus.mem_req         = v.mreq;
        bus.mem_ack         = v.mack;
    endtask

    // Called just after a rising edge: apply inputs, sample Mealy outputs mid-cycle, then registers after the edge
    task automatic step(in_t v, output ctrl_t c, output logic [CW-1:0] cnt, output logic err);
        drive(v);
        #3;
        c = dut_ctrl();
        @(posedge clk);
        #1;
        cnt = bus.stall_count;
        err = bus.mem_timeout_err;
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_busy = 0; m_held = 0; m_wait = 0; m_err = 0; m_stalls = 0;
    endtask

    // Rule-level reference: the first applicable hazard decides this cycle's controls
    task automatic model_step(in_t v, output ctrl_t exp);
        bit hazard;
        bit counted;
        bit flows;
        logic [4:0] srcs [2];
        bit         used [2];
        srcs[0] = v.rs1; srcs[1] = v.rs2;
        used[0] = v.u1;  used[1] = v.u2;
        hazard = 0;
        if (v.ld && v.rd != 5'd0)
            for (int s = 0; s < 2; s++)
                if (used[s] && srcs[s] == v.rd) hazard = 1;

        counted = 0;
        flows   = 0;
        exp     = C_DEF;
        if (v.mreq && !v.mack) begin
            exp = C_MEM;
            counted = 1;
            if (m_busy && v.mdd) m_held = 1;
            if (m_wait < 65535) m_wait++;
            if (m_wait >= int'(TMO)) m_err = 1;
        end else begin
            m_wait = 0;
            if (m_busy) begin
                if (v.mdd || m_held) begin
                    m_busy = 0;
                    m_held = 0;
                    flows  = 1;
                end else begin
                    exp = C_MD;
                    counted = 1;
                end
            end else if (v.mdv) begin
                exp = C_MDS;
                m_busy = 1;
                counted = 1;
            end else begin
                flows = 1;
            end
            if (flows) begin
                if (v.br) exp = C_BR;
                else if (hazard) begin
                    exp = C_LU;
                    counted = 1;
                end
            end
        end
        if (counted && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t            vecs [13];
        ctrl_t           c;
        logic [CW-1:0]   cnt;
        logic            err;
        longint          exp_cnt;
        in_t             idle;
        in_t             v;
        ctrl_t           exp;
        int              burst;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_DEF, 0};
        vecs[1]  = '{mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0), C_LU,  1};
        vecs[2]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0), C_DEF, 0};
        vecs[3]  = '{mk(7, 2, 0, 1, 7, 1, 0, 0, 0, 0, 0), C_DEF, 0};
        vecs[4]  = '{mk(7, 2, 1, 0, 7, 1, 0, 0, 0, 0, 0), C_LU,  1};
        vecs[5]  = '{mk(9, 9, 1, 1, 9, 0, 0, 0, 0, 0, 0), C_DEF, 0};
        vecs[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_BR,  0};
        vecs[7]  = '{mk(3, 3, 1, 1, 3, 1, 1, 0, 0, 0, 0), C_BR,  0};
        vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_DEF, 0};
        vecs[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_DEF, 0};
        vecs[10] = '{mk(4, 4, 1, 1, 4, 1, 1, 0, 0, 1, 0), C_MEM, 1};
        vecs[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_MEM, 1};
        vecs[12] = '{mk(31, 31, 1, 1, 31, 1, 0, 0, 0, 0, 0), C_LU, 1};

        rst_n = 1'b1;
        drive(idle);
        #1;
        rst_n = 1'b0;
        #2;
        chk("reset_ctrl", 64'(dut_ctrl()), 64'(C_DEF));
        chk("reset_count", 64'(bus.stall_count), 64'd0);
        chk("reset_err", 64'(bus.mem_timeout_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table, all issued from RUN
        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].in, c, cnt, err);
            exp_cnt += vecs[i].inc;
            chk($sformatf("vec%0d_ctrl", i), 64'(c), 64'(vecs[i].ctrl));
            chk($sformatf("vec%0d_count", i), 64'(cnt), 64'(exp_cnt));
        end

        // MUL/DIV: start, four busy cycles, release when md_done arrives
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
        chk("md_start", 64'(c), 64'(C_MDS));
        for (int k = 0; k < 4; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
            chk($sformatf("md_busy%0d", k), 64'(c), 64'(C_MD));
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), c, cnt, err);
        chk("md_release", 64'(c), 64'(C_DEF));
        exp_cnt += 5;
        chk("md_count", 64'(cnt), 64'(exp_cnt));
        step(idle, c, cnt, err);
        chk("md_after", 64'(c), 64'(C_DEF));

        // md_done swallowed during a mem stall must still release MD afterwards
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
        chk("dq_start", 64'(c), 64'(C_MDS));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), c, cnt, err);
        chk("dq_mem1", 64'(c), 64'(C_MEM));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), c, cnt, err);
        chk("dq_mem2", 64'(c), 64'(C_MEM));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), c, cnt, err);
        chk("dq_mem3", 64'(c), 64'(C_MEM));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), c, cnt, err);
        chk("dq_release", 64'(c), 64'(C_DEF));
        exp_cnt += 4;
        chk("dq_count", 64'(cnt), 64'(exp_cnt));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
        chk("dq_restart", 64'(c), 64'(C_MDS));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), c, cnt, err);
        chk("dq_done2", 64'(c), 64'(C_DEF));

        // Watchdog: sets on the 8th consecutive wait, sticky until reset
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), c, cnt, err);
            chk($sformatf("tmo_err%0d", k), 64'(err), (k >= 8) ? 64'd1 : 64'd0);
        end
        chk("tmo_count", 64'(cnt), 64'd10);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), c, cnt, err);
        chk("tmo_sticky_ack", 64'(err), 64'd1);
        step(idle, c, cnt, err);
        chk("tmo_sticky_idle", 64'(err), 64'd1);
        do_reset();
        chk("tmo_cleared", 64'(bus.mem_timeout_err), 64'd0);
        // Counter restarts after a clear, so seven waits must not trip it
        for (int k = 0; k < 7; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), c, cnt, err);
        step(idle, c, cnt, err);
        for (int k = 0; k < 7; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), c, cnt, err);
        chk("tmo_split_runs", 64'(err), 64'd0);

        // Async reset in the middle of MD_BUSY
        do_reset();
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
        chk("rst_md_busy", 64'(c), 64'(C_MD));
        drive(idle);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'(dut_ctrl()), 64'(C_DEF));
        chk("rst_mid_count", 64'(bus.stall_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), c, cnt, err);
        chk("rst_new_start", 64'(c), 64'(C_MDS));
        step(idle, c, cnt, err);
        chk("rst_new_busy", 64'(c), 64'(C_MD));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), c, cnt, err);
        chk("rst_new_done", 64'(c), 64'(C_DEF));
        chk("rst_new_count", 64'(cnt), 64'd2);

        // Randomized traffic against the rule model
        do_reset();
        burst = 0;
        for (int n = 0; n < 600; n++) begin
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 3));
            v.ld   = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 4) == 0);
            v.mdv  = ($urandom_range(0, 3) == 0);
            v.mdd  = ($urandom_range(0, 4) == 0);
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = int'($urandom_range(6, 12));
            if (burst > 0) begin
                v.mreq = 1'b1;
                v.mack = 1'b0;
                burst--;
            end else begin
                v.mreq = ($urandom_range(0, 3) == 0);
                v.mack = 1'($urandom_range(0, 1));
            end
            model_step(v, exp);
            step(v, c, cnt, err);
            chk($sformatf("rnd%0d_ctrl", n), 64'(c), 64'(exp));
            chk($sformatf("rnd%0d_count", n), 64'(cnt), 64'(m_stalls));
            chk($sformatf("rnd%0d_err", n), 64'(err), 64'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
